// File: rtl/tpu_fxp_pkg.sv
// Shared Q8.8 fixed-point types and constants for the TPU datapath lanes.
package tpu_fxp_pkg;

  typedef logic signed [15:0] fxp16_t;

  localparam int unsigned FXP_FRAC_BITS = 8;
  localparam fxp16_t      FXP_ZERO      = '0;

endpackage

// File: rtl/fxp_mul.sv
// Signed Q8.8 x Q8.8 multiply; full product shifted back to Q8.8 and truncated
// (rounds toward negative infinity, no saturation).
module fxp_mul
  import tpu_fxp_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] product
);

  logic signed [31:0] full_prod;

  // Widen both operands as signed, then drop the extra fraction bits.
  always_comb begin
    full_prod = 32'(fxp16_t'(a)) * 32'(fxp16_t'(b));
    product   = 16'(full_prod >>> FXP_FRAC_BITS);
  end

endmodule

// File: rtl/lr_h_fifo.sv
// H cache FIFO: storage, wrap-around pointers, occupancy, full/empty flags
// and a registered read port. Reports dropped pushes and missed pops so the
// parent can keep sticky error flags.
module lr_h_fifo
  import tpu_fxp_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_drop,
  output logic                     pop_miss
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count_next;
  logic              push_ok;
  logic              pop_ok;

  // Accept/reject decisions; clear overrides both. A pop frees a slot in the
  // same cycle, so a push into a full cache succeeds when paired with a pop.
  // There is no bypass: a pop on empty misses even if a push lands alongside.
  always_comb begin
    pop_ok     = pop & ~empty & ~clear;
    push_ok    = push & ~clear & (~full | pop_ok);
    push_drop  = push & ~clear & full & ~pop_ok;
    pop_miss   = pop & ~clear & empty;
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (push_ok && !pop_ok) begin
      count_next = count + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      count_next = count - CNT_ONE;
    end
  end

  // Cache storage; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy, status flags and the registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      end
      count    <= count_next;
      full     <= (count_next == CNT_FULL);
      empty    <= (count_next == '0);
      rd_valid <= pop_ok;
      rd_data  <= pop_ok ? mem[rd_ptr] : '0;
    end
  end

endmodule

// File: rtl/leaky_relu_fwd_h_cache.sv
// Forward leaky-ReLU lane with an H cache for backpropagation replay.
// The activation register and sticky error flags live here; the cache
// itself is lr_h_fifo.
module leaky_relu_fwd_h_cache
  import tpu_fxp_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lr_valid_in,
  input  logic [DATA_W-1:0]        lr_data_in,
  input  logic [DATA_W-1:0]        lr_leak_factor_in,
  input  logic                     lr_store_en_in,
  output logic                     lr_valid_out,
  output logic [DATA_W-1:0]        lr_data_out,
  input  logic                     h_pop_in,
  output logic                     h_valid_out,
  output logic [DATA_W-1:0]        h_data_out,
  input  logic                     clear_in,
  output logic                     full_out,
  output logic                     empty_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  logic [DATA_W-1:0] leak_prod;
  logic [DATA_W-1:0] act;
  logic              push_drop;
  logic              pop_miss;

  fxp_mul u_leak_mul (
    .a       (lr_data_in),
    .b       (lr_leak_factor_in),
    .product (leak_prod)
  );

  lr_h_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_h_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_in),
    .push      (lr_valid_in & lr_store_en_in),
    .pop       (h_pop_in),
    .wr_data   (lr_data_in),
    .rd_valid  (h_valid_out),
    .rd_data   (h_data_out),
    .full      (full_out),
    .empty     (empty_out),
    .count     (count_out),
    .push_drop (push_drop),
    .pop_miss  (pop_miss)
  );

  // Negative inputs take the leak product; zero and positive pass through.
  always_comb begin
    act = lr_data_in[DATA_W-1] ? leak_prod : lr_data_in;
  end

  // Activation register: one-cycle latency, zero data when no valid sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr_valid_out <= 1'b0;
      lr_data_out  <= FXP_ZERO;
    end else begin
      lr_valid_out <= lr_valid_in;
      lr_data_out  <= lr_valid_in ? act : FXP_ZERO;
    end
  end

  // Sticky error flags; clear wipes them and suppresses new events that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (clear_in) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (push_drop) overflow_err  <= 1'b1;
      if (pop_miss)  underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_leaky_relu_fwd_h_cache.sv
// Scoreboard bench for leaky_relu_fwd_h_cache (DEPTH = 4).
module tb_leaky_relu_fwd_h_cache;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lr_valid_in;
  logic [15:0] lr_data_in;
  logic [15:0] lr_leak_factor_in;
  logic        lr_store_en_in;
  logic        lr_valid_out;
  logic [15:0] lr_data_out;
  logic        h_pop_in;
  logic        h_valid_out;
  logic [15:0] h_data_out;
  logic        clear_in;
  logic        full_out;
  logic        empty_out;
  logic [2:0]  count_out;
  logic        overflow_err;
  logic        underflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] fq[$];  // expected activations
  logic [15:0] hq[$];  // expected replayed H values
  logic [15:0] mq[$];  // contents of the cache as the bench expects them

  leaky_relu_fwd_h_cache #(.DEPTH(DEPTH), .DATA_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .lr_valid_in       (lr_valid_in),
    .lr_data_in        (lr_data_in),
    .lr_leak_factor_in (lr_leak_factor_in),
    .lr_store_en_in    (lr_store_en_in),
    .lr_valid_out      (lr_valid_out),
    .lr_data_out       (lr_data_out),
    .h_pop_in          (h_pop_in),
    .h_valid_out       (h_valid_out),
    .h_data_out        (h_data_out),
    .clear_in          (clear_in),
    .full_out          (full_out),
    .empty_out         (empty_out),
    .count_out         (count_out),
    .overflow_err      (overflow_err),
    .underflow_err     (underflow_err)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (lr_valid_out === 1'b1) begin
        if (fq.size() == 0) check("fwd_unexpected_valid", 1, 0);
        else check("fwd_data", {16'h0, lr_data_out}, {16'h0, fq.pop_front()});
      end
      if (h_valid_out === 1'b1) begin
        if (hq.size() == 0) check("h_unexpected_valid", 1, 0);
        else check("h_data", {16'h0, h_data_out}, {16'h0, hq.pop_front()});
      end
    end
  end

  // One clock of stimulus; expected responses are queued at issue time.
  task automatic cyc(input logic v, input logic [15:0] d, input logic [15:0] exp_act,
                     input logic st, input logic pop, input logic clr);
    logic pop_ok;
    lr_valid_in    = v;
    lr_data_in     = d;
    lr_store_en_in = st;
    h_pop_in       = pop;
    clear_in       = clr;
    if (v) fq.push_back(exp_act);
    if (clr) begin
      mq.delete();
    end else begin
      pop_ok = pop && (mq.size() != 0);
      if (pop_ok) hq.push_back(mq.pop_front());
      if (v && st && (mq.size() < DEPTH)) mq.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_drained();
    check("fwd_queue_drained", fq.size(), 0);
    check("h_queue_drained", hq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lr_valid"}, lr_valid_out, 0);
    check({tag, "_lr_data"}, lr_data_out, 0);
    check({tag, "_h_valid"}, h_valid_out, 0);
    check({tag, "_h_data"}, h_data_out, 0);
    check({tag, "_count"}, count_out, 0);
    check({tag, "_full"}, full_out, 0);
    check({tag, "_empty"}, empty_out, 1);
    check({tag, "_ovf"}, overflow_err, 0);
    check({tag, "_unf"}, underflow_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst               = 1'b1;
    lr_valid_in       = 1'b0;
    lr_data_in        = '0;
    lr_leak_factor_in = 16'h0080;
    lr_store_en_in    = 1'b0;
    h_pop_in          = 1'b0;
    clear_in          = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Forward path, leak 0.5
    cyc(1, 16'h0300, 16'h0300, 0, 0, 0);
    cyc(1, 16'hFE00, 16'hFF00, 0, 0, 0);
    cyc(1, 16'h0000, 16'h0000, 0, 0, 0);
    cyc(1, 16'h8000, 16'hC000, 0, 0, 0);
    cyc(1, 16'h7FFF, 16'h7FFF, 0, 0, 0);
    cyc(0, 16'h0500, 16'h0000, 1, 0, 0);
    check("invalid_fwd_data_zero", lr_data_out, 0);
    check("invalid_fwd_no_store", count_out, 0);

    // Store then replay
    cyc(1, 16'h0100, 16'h0100, 1, 0, 0);
    cyc(1, 16'hFF00, 16'hFF80, 1, 0, 0);
    cyc(1, 16'h0280, 16'h0280, 1, 0, 0);
    check("store_count3", count_out, 3);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("replay_count0", count_out, 0);
    check("replay_empty", empty_out, 1);
    idle(1);
    check_drained();

    // Overflow at DEPTH = 4
    cyc(1, 16'h0010, 16'h0010, 1, 0, 0);
    cyc(1, 16'h0020, 16'h0020, 1, 0, 0);
    cyc(1, 16'h0030, 16'h0030, 1, 0, 0);
    cyc(1, 16'h0040, 16'h0040, 1, 0, 0);
    check("ovf_full", full_out, 1);
    check("ovf_count4", count_out, 4);
    check("ovf_not_yet", overflow_err, 0);
    cyc(1, 16'h0050, 16'h0050, 1, 0, 0);
    check("ovf_flag", overflow_err, 1);
    check("ovf_count_held", count_out, 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
    check("ovf_drain_empty", empty_out, 1);
    check("ovf_no_underflow", underflow_err, 0);
    idle(1);
    check_drained();

    // Wrap with simultaneous push/pop at full occupancy
    for (int i = 0; i < 4; i++) cyc(1, 16'h0A00 + 16'(i), 16'h0A00 + 16'(i), 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 16'h1000 + 16'(i), 16'h1000 + 16'(i), 1, 1, 0);
      check("wrap_count", count_out, 4);
      check("wrap_full", full_out, 1);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
    check("wrap_empty", empty_out, 1);
    check("wrap_no_underflow", underflow_err, 0);
    // Pop on empty with a simultaneous push
    cyc(1, 16'h0123, 16'h0123, 1, 1, 0);
    check("empty_pop_unf", underflow_err, 1);
    check("empty_pop_h_valid", h_valid_out, 0);
    check("empty_pop_h_data", h_data_out, 0);
    check("empty_pop_count1", count_out, 1);

    // Clear with 3 entries and both flags set
    cyc(1, 16'h0200, 16'h0200, 1, 0, 0);
    cyc(1, 16'h0201, 16'h0201, 1, 0, 0);
    check("pre_clear_count3", count_out, 3);
    check("pre_clear_ovf", overflow_err, 1);
    check("pre_clear_unf", underflow_err, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("clear_count", count_out, 0);
    check("clear_empty", empty_out, 1);
    check("clear_ovf", overflow_err, 0);
    check("clear_unf", underflow_err, 0);
    cyc(1, 16'h0777, 16'h0777, 1, 0, 0);
    check("post_clear_count1", count_out, 1);
    cyc(0, 0, 0, 0, 1, 0);
    idle(1);
    check_drained();

    // Reset mid-replay with two entries left and outputs in flight
    cyc(1, 16'h0111, 16'h0111, 1, 0, 0);
    cyc(1, 16'h0222, 16'h0222, 1, 0, 0);
    cyc(1, 16'h0333, 16'h0333, 1, 0, 0);
    cyc(1, 16'h0444, 16'h0444, 0, 1, 0);
    check("pre_rst_h_valid", h_valid_out, 1);
    check("pre_rst_count2", count_out, 2);
    lr_valid_in = 1'b0;
    h_pop_in    = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    fq.delete();
    hq.delete();
    mq.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    cyc(0, 0, 0, 0, 1, 0);
    check("post_rst_unf", underflow_err, 1);
    check("post_rst_h_valid", h_valid_out, 0);
    check("post_rst_count", count_out, 0);
    idle(2);
    check_drained();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
